// File: rtl/cordic_arbiter_if.sv
// ============================================================================
// Module   : cordic_arbiter_if
// Purpose  : Requester, core and result signals of the CORDIC arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_arbiter_if #(
  parameter int N_FRAC = 7
);
  localparam int W = N_FRAC + 1;

  logic         req0_valid_i;
  logic         req0_ready_o;
  logic [W-1:0] req0_x_i;
  logic [W-1:0] req0_y_i;
  logic [W-1:0] req0_z_i;
  logic         req1_valid_i;
  logic         req1_ready_o;
  logic [W-1:0] req1_x_i;
  logic [W-1:0] req1_y_i;
  logic [W-1:0] req1_z_i;

  logic         core_start_o;
  logic [W-1:0] core_x_o;
  logic [W-1:0] core_y_o;
  logic [W-1:0] core_z_o;
  logic         core_done_i;
  logic [W-1:0] core_x_i;
  logic [W-1:0] core_y_i;
  logic [W-1:0] core_z_i;

  logic [1:0]   res_valid_o;
  logic [W-1:0] res_x_o;
  logic [W-1:0] res_y_o;
  logic [W-1:0] res_z_o;
  logic         busy_o;
  logic         timeout_err_o;

  // Arbiter view.
  modport slave (
    input  req0_valid_i, req0_x_i, req0_y_i, req0_z_i,
    input  req1_valid_i, req1_x_i, req1_y_i, req1_z_i,
    input  core_done_i, core_x_i, core_y_i, core_z_i,
    output req0_ready_o, req1_ready_o,
    output core_start_o, core_x_o, core_y_o, core_z_o,
    output res_valid_o, res_x_o, res_y_o, res_z_o,
    output busy_o, timeout_err_o
  );

  // Requester / core view.
  modport master (
    output req0_valid_i, req0_x_i, req0_y_i, req0_z_i,
    output req1_valid_i, req1_x_i, req1_y_i, req1_z_i,
    output core_done_i, core_x_i, core_y_i, core_z_i,
    input  req0_ready_o, req1_ready_o,
    input  core_start_o, core_x_o, core_y_o, core_z_o,
    input  res_valid_o, res_x_o, res_y_o, res_z_o,
    input  busy_o, timeout_err_o
  );
endinterface

`default_nettype wire

// File: rtl/cordic_arbiter.sv
// ============================================================================
// Module   : cordic_arbiter
// Purpose  : Round-robin sharing of one iterative CORDIC core by two channels.
//            Optional WAIT watchdog enabled by macro CORDIC_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_arbiter #(
  parameter int N_FRAC  = 7,
  parameter int TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cordic_arbiter_if.slave  bus
);
  localparam int c_W = N_FRAC + 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_WAIT    = 2'd2;
  localparam logic [1:0] c_DELIVER = 2'd3;

  logic [1:0]     r_state;
  logic           r_last_grant;
  logic           r_owner;
  logic [c_W-1:0] r_core_x, r_core_y, r_core_z;
  logic [c_W-1:0] r_res_x, r_res_y, r_res_z;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_timeout;

  // On contention the channel that did not win last time is granted.
  assign w_idle   = (r_state == c_IDLE);
  assign w_grant0 = bus.req0_valid_i && (!bus.req1_valid_i || r_last_grant);
  assign w_grant1 = bus.req1_valid_i && (!bus.req0_valid_i || !r_last_grant);
  assign w_accept = w_idle && (w_grant0 || w_grant1);

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
  logic [7:0] r_wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == c_ISSUE) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == c_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // A done arriving on the expiry cycle takes priority over the abort.
  assign w_timeout = (r_state == c_WAIT) && !bus.core_done_i && (r_wait_cnt == c_TIMEOUT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= c_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_z     <= '0;
      r_res_x      <= '0;
      r_res_y      <= '0;
      r_res_z      <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_state      <= c_ISSUE;
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
            r_core_x     <= w_grant1 ? bus.req1_x_i : bus.req0_x_i;
            r_core_y     <= w_grant1 ? bus.req1_y_i : bus.req0_y_i;
            r_core_z     <= w_grant1 ? bus.req1_z_i : bus.req0_z_i;
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (bus.core_done_i) begin
            r_res_x <= bus.core_x_i;
            r_res_y <= bus.core_y_i;
            r_res_z <= bus.core_z_i;
            r_state <= c_DELIVER;
          end else if (w_timeout) begin
            r_state <= c_IDLE;
          end
        end
        c_DELIVER: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready_o  = w_idle && w_grant0;
  assign bus.req1_ready_o  = w_idle && w_grant1;
  assign bus.core_start_o  = (r_state == c_ISSUE);
  assign bus.core_x_o      = r_core_x;
  assign bus.core_y_o      = r_core_y;
  assign bus.core_z_o      = r_core_z;
  assign bus.res_valid_o   = {(r_state == c_DELIVER) && r_owner,
                              (r_state == c_DELIVER) && !r_owner};
  assign bus.res_x_o       = r_res_x;
  assign bus.res_y_o       = r_res_y;
  assign bus.res_z_o       = r_res_z;
  assign bus.busy_o        = !w_idle;
  assign bus.timeout_err_o = w_timeout;

endmodule

`default_nettype wire
